// File: rtl/alu_hs.sv
// Handshaked WIDTH-bit ALU with registered result and zero/carry/neg/ovf flags.
// Define ALU_MUL_EN to add the iterative shift-add multiplier (op 9).
module alu_hs #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] accum,
  input  logic [WIDTH-1:0] data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             carry,
  output logic             neg,
  output logic             ovf,
  output logic             busy
);

  localparam logic [3:0] OP_PASS = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_LDA  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;

  logic             accept;
  logic             is_mul;
  logic             alu_load;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_v;

  assign accept   = in_valid && in_ready;
  assign alu_load = accept && !is_mul;
  assign sum      = {1'b0, accum} + {1'b0, data};
  assign dif      = {1'b0, accum} - {1'b0, data};

  always_comb begin
    res   = accum;
    res_c = 1'b0;
    res_v = 1'b0;
    case (op)
      OP_PASS: res = accum;
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (accum[WIDTH-1] == data[WIDTH-1]) &&
                (sum[WIDTH-1] != accum[WIDTH-1]);
      end
      OP_SUB: begin
        res   = dif[WIDTH-1:0];
        res_c = dif[WIDTH];
        res_v = (accum[WIDTH-1] != data[WIDTH-1]) &&
                (dif[WIDTH-1] != accum[WIDTH-1]);
      end
      OP_AND: res = accum & data;
      OP_OR:  res = accum | data;
      OP_XOR: res = accum ^ data;
      OP_LDA: res = data;
      OP_SHL: begin
        res   = {accum[WIDTH-2:0], 1'b0};
        res_c = accum[WIDTH-1];
      end
      OP_SHR: begin
        res   = {1'b0, accum[WIDTH-1:1]};
        res_c = accum[0];
      end
      default: res = accum;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, MUL} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic               mul_last;

  assign is_mul   = (op == 4'd9);
  assign mul_last = (state == MUL) && (cnt == CW'(WIDTH - 1));
  assign acc_nxt  = acc + (mplier[0] ? mcand : '0);
  assign busy     = (state == MUL);
  assign in_ready = !rst && (state == IDLE) &&
                    (!out_valid || out_ready);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && is_mul) state_nxt = MUL;
      MUL:  if (mul_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // One multiplier bit per cycle; final partial sum is taken from acc_nxt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (accept && is_mul) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, accum};
      mplier <= data;
    end else if (state == MUL) begin
      cnt    <= cnt + 1'b1;
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end
`else
  assign is_mul   = 1'b0;
  assign busy     = 1'b0;
  assign in_ready = !rst && (!out_valid || out_ready);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else if (alu_load) begin
      out       <= res;
      zero      <= (res == '0);
      carry     <= res_c;
      neg       <= res[WIDTH-1];
      ovf       <= res_v;
      out_valid <= 1'b1;
`ifdef ALU_MUL_EN
    end else if (mul_last) begin
      out       <= acc_nxt[WIDTH-1:0];
      zero      <= (acc_nxt[WIDTH-1:0] == '0);
      carry     <= |acc_nxt[2*WIDTH-1:WIDTH];
      neg       <= acc_nxt[WIDTH-1];
      ovf       <= 1'b0;
      out_valid <= 1'b1;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_hs.sv
// Directed self-checking bench for alu_hs (WIDTH=8).
// Multiplier checks follow ALU_MUL_EN when it is defined for the build.
module tb_alu_hs;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] accum;
  logic [W-1:0] data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         zero;
  logic         carry;
  logic         neg;
  logic         ovf;
  logic         busy;

  int tests  = 0;
  int failed = 0;

  alu_hs #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .accum(accum), .data(data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zero(zero), .carry(carry),
    .neg(neg), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] d;
    logic [W-1:0] r;
    logic         z;
    logic         c;
    logic         n;
    logic         v;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] res_word();
    return {19'd0, out_valid, busy, out, zero, carry, neg, ovf};
  endfunction

  function automatic logic [31:0] exp_word(input logic [W-1:0] r,
      input logic z, c, n, v);
    return {19'd0, 1'b1, 1'b0, r, z, c, n, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] d);
    in_valid = 1'b1;
    op       = o;
    accum    = a;
    data     = d;
  endtask

  logic [31:0] held;
  logic        seen;

  initial begin
    vt.push_back('{"add_carry", 4'd1, 8'hF0, 8'h20, 8'h10, 0, 1, 0, 0});
    vt.push_back('{"add_ovf",   4'd1, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 1});
    vt.push_back('{"sub_ovf",   4'd2, 8'h80, 8'h01, 8'h7F, 0, 0, 0, 1});
    vt.push_back('{"sub_zero",  4'd2, 8'h05, 8'h05, 8'h00, 1, 0, 0, 0});
    vt.push_back('{"sub_borrow",4'd2, 8'h01, 8'h02, 8'hFF, 0, 1, 1, 0});
    vt.push_back('{"and",       4'd3, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0});
    vt.push_back('{"or",        4'd4, 8'hF0, 8'h0F, 8'hFF, 0, 0, 1, 0});
    vt.push_back('{"xor",       4'd5, 8'hAA, 8'hFF, 8'h55, 0, 0, 0, 0});
    vt.push_back('{"lda_zero",  4'd6, 8'h33, 8'h00, 8'h00, 1, 0, 0, 0});
    vt.push_back('{"shl",       4'd7, 8'h81, 8'h00, 8'h02, 0, 1, 0, 0});
    vt.push_back('{"shr",       4'd8, 8'h81, 8'h00, 8'h40, 0, 1, 0, 0});
    vt.push_back('{"pass",      4'd0, 8'h9C, 8'h11, 8'h9C, 0, 0, 1, 0});
    vt.push_back('{"op12_pass", 4'd12,8'h00, 8'h55, 8'h00, 1, 0, 0, 0});
`ifndef ALU_MUL_EN
    vt.push_back('{"mul_as_pass",4'd9,8'h12, 8'h10, 8'h12, 0, 0, 0, 0});
`endif

    rst = 1'b1;
    in_valid = 1'b0;
    op = '0;
    accum = '0;
    data = '0;
    out_ready = 1'b1;
    #12;
    chk("reset_state", {in_ready, out_valid, busy, out, zero, carry, neg, ovf},
        32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rel", {31'd0, in_ready}, 32'd1);
    tick();

    // Single-cycle ops, one at a time: result visible one edge after accept.
    foreach (vt[i]) begin
      drive(vt[i].op, vt[i].a, vt[i].d);
      chk({vt[i].name, "_rdy"}, {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      chk(vt[i].name, res_word(),
          exp_word(vt[i].r, vt[i].z, vt[i].c, vt[i].n, vt[i].v));
      tick();
      chk({vt[i].name, "_drain"}, {31'd0, out_valid}, 32'd0);
    end

    // Back-to-back throughput: four results on four consecutive cycles.
    drive(4'd1, 8'h01, 8'h02);
    tick();
    chk("tp_add", res_word(), exp_word(8'h03, 0, 0, 0, 0));
    chk("tp_rdy1", {31'd0, in_ready}, 32'd1);
    drive(4'd5, 8'h0F, 8'hF0);
    tick();
    chk("tp_xor", res_word(), exp_word(8'hFF, 0, 0, 1, 0));
    drive(4'd7, 8'h81, 8'h00);
    tick();
    chk("tp_shl", res_word(), exp_word(8'h02, 0, 1, 0, 0));
    drive(4'd6, 8'h77, 8'h00);
    tick();
    chk("tp_lda", res_word(), exp_word(8'h00, 1, 0, 0, 0));
    in_valid = 1'b0;
    tick();
    chk("tp_drain", {31'd0, out_valid}, 32'd0);

    // Back-pressure: result held 3 cycles, then consumed exactly once.
    out_ready = 1'b0;
    drive(4'd1, 8'h10, 8'h20);
    tick();
    in_valid = 1'b0;
    held = res_word();
    chk("bp_load", held, exp_word(8'h30, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      chk("bp_rdy_low", {31'd0, in_ready}, 32'd0);
      tick();
      chk("bp_hold", res_word(), held);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_rise", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_consumed", {31'd0, out_valid}, 32'd0);
    tick();
    chk("bp_once", {31'd0, out_valid}, 32'd0);

    // Async reset drops a held result immediately.
    out_ready = 1'b0;
    drive(4'd6, 8'h00, 8'h5A);
    tick();
    in_valid = 1'b0;
    chk("rst_pre", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async", {in_ready, out_valid, out, zero, carry, neg, ovf},
        32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst_release", {30'd0, in_ready, out_valid}, 32'd2);
    tick();

`ifdef ALU_MUL_EN
    // MUL 0x12*0x10 = 0x120: busy for 8 cycles, result on 8th edge.
    drive(4'd9, 8'h12, 8'h10);
    tick();
    in_valid = 1'b0;
    for (int k = 1; k < 8; k++) begin
      chk("mul_wait", {29'd0, busy, in_ready, out_valid}, 32'd4);
      tick();
    end
    chk("mul_wait8", {29'd0, busy, in_ready, out_valid}, 32'd4);
    tick();
    chk("mul_result", res_word(), exp_word(8'h20, 0, 1, 0, 0));
    tick();
    chk("mul_drain", {31'd0, out_valid}, 32'd0);

    // Reset in the 4th MUL cycle aborts with no result ever shown.
    drive(4'd9, 8'h0F, 8'h0F);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("abort_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_async", {30'd0, busy, out_valid}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("abort_ready", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (out_valid || busy) seen = 1'b1;
    end
    chk("abort_no_result", {31'd0, seen}, 32'd0);
`else
    // Without the multiplier, busy never rises.
    drive(4'd9, 8'hA5, 8'h03);
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      in_valid = 1'b0;
      if (busy) seen = 1'b1;
    end
    chk("no_busy", {31'd0, seen}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/alu_hs.md
Name: alu_hs

Overview:
- Parametrised, handshaked successor to the VeriRISC 8-bit ALU: configurable WIDTH, registered result and full flag set (zero/carry/neg/ovf), extended opcode set.
- Optional iterative multi-cycle multiplier.
- Sits between decode/accumulator and the writeback path; valid/ready on both sides lets the controller stall on multi-cycle ops and back-pressure.

Parameters:
WIDTH, 8, datapath width in bits (>=4)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  operation request valid
in_ready  output  1  block can accept an operation this cycle
op  input  4  operation code (encoding below)
accum  input  WIDTH  operand A (accumulator)
data  input  WIDTH  operand B (memory/immediate)
out_valid  output  1  result and flags valid
out_ready  input  1  consumer accepts result this cycle
out  output  WIDTH  registered result
zero  output  1  registered: result == 0
carry  output  1  registered carry/borrow/high-half flag
neg  output  1  registered: out[WIDTH-1]
ovf  output  1  registered signed overflow
busy  output  1  multiply in progress

Behaviour:
- One clock (clk); reset asynchronous, active-high (rst). While rst=1: state IDLE, out=0, zero=0, carry=0, neg=0, ovf=0, out_valid=0, busy=0, in_ready=0. Release takes effect at the next clk edge with no further latency.
- Accept = in_valid && in_ready at a rising edge. Operands and op are sampled only at accept.
- in_ready = !rst && state==IDLE && (!out_valid || out_ready). Combinational; permits one op per cycle when the consumer never stalls.
- Result hold: while out_valid && !out_ready, out and all flags hold stable. out_valid clears on out_ready unless a new result loads on the same edge.
- States:
  - IDLE: single-cycle op → result and flags load at the accepting edge; out_valid=1 the next cycle (latency 1). MUL → MUL state.
  - MUL: shift-add, one multiplier bit per cycle, WIDTH cycles, busy=1. Result loads on the WIDTH-th edge after accept, then → IDLE with out_valid=1.
- Op encoding:
  - 0 PASS: accum
  - 1 ADD: accum+data
  - 2 SUB: accum-data
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 LDA: data
  - 7 SHL: accum<<1
  - 8 SHR: logical accum>>1
  - 9 MUL: low WIDTH bits of accum*data
  - 10-15: PASS
- Flags:
  - zero, neg: from the loaded result.
  - ADD: carry = carry-out of bit WIDTH-1; ovf = operands same sign and result sign differs.
  - SUB: carry = borrow (1 iff accum<data unsigned); ovf = operands differ in sign and result sign differs from accum.
  - SHL: carry = accum[WIDTH-1]. SHR: carry = accum[0].
  - MUL: carry = 1 iff high WIDTH bits of the product are nonzero.
  - All other ops: carry=0. ovf=0 for everything except ADD/SUB.
- All arithmetic unsigned modulo 2^WIDTH; ovf interprets operands as two's complement.
- Reset during MUL aborts the operation; no partial result is ever presented.
- in_valid while busy: ignored (in_ready=0). Requester holds op and operands until accept.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: MUL state, multiplier registers and busy logic as above.
- Undefined: no MUL state or multiplier hardware; op 9 executes as PASS with latency 1; busy tied 0; in_ready = !rst && (!out_valid || out_ready).

Test Plan:
- WIDTH=8, ADD accum=0xF0 data=0x20, out_ready=1 → out=0x10, carry=1, zero=0, neg=0, ovf=0, out_valid high the cycle after accept.
- SUB cases:
  - 0x80-0x01 → 0x7F, ovf=1, carry=0.
  - 0x05-0x05 → 0x00, zero=1.
  - 0x01-0x02 → 0xFF, carry=1, neg=1.
- Back-pressure: ADD accepted with out_ready=0 for 3 cycles → in_ready=0 and out/flags stable throughout; in_ready=1 in the cycle out_ready rises; result consumed once.
- Throughput: 4 consecutive ops (ADD, XOR, SHL 0x81, LDA 0x00), out_ready=1 → 4 results on 4 consecutive cycles. SHL gives 0x02 with carry=1; LDA gives zero=1.
- ALU_MUL_EN defined, MUL 0x12*0x10 → out=0x20, carry=1; busy=1 and in_ready=0 for 8 cycles; out_valid rises exactly 8 cycles after accept. Repeat undefined → out=0x12 after 1 cycle.
- Reset mid-MUL: assert rst during 4th MUL cycle → out_valid/busy drop immediately (async); after release in_ready=1, no result ever emitted for the aborted MUL.
